// File: rtl/biu_defs.sv
// Shared definitions for the BIU prefetch stage: FSM encodings, queue depth,
// physical address width and small arithmetic helpers.
package biu_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fsm_state_e;

  localparam int QUEUE_DEPTH = 6;
  localparam int PHYS_AW     = 20;

  // Real-mode style segment:offset translation; carry out of bit 19 is lost.
  function automatic logic [PHYS_AW-1:0] phys_addr(input logic [15:0] seg,
                                                   input logic [15:0] off);
    return {seg, 4'b0000} + {4'b0000, off};
  endfunction

  // Advance a circular-buffer pointer by 0..2 entries, modulo QUEUE_DEPTH.
  function automatic logic [2:0] ptr_add(input logic [2:0] p,
                                         input logic [1:0] n);
    logic [3:0] s;
    s = {1'b0, p} + {2'b00, n};
    if (s >= 4'(QUEUE_DEPTH)) s = s - 4'(QUEUE_DEPTH);
    return s[2:0];
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// 6-entry byte circular buffer: pushes 0..2 bytes and pops 1 byte per cycle,
// synchronous clear has priority over push and pop.
module prefetch_fifo
  import biu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [1:0]  push_num,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic [7:0]  head,
  output logic [2:0]  count
);

  logic [7:0] mem_q [QUEUE_DEPTH];
  logic [7:0] mem_d [QUEUE_DEPTH];
  logic [2:0] rd_q, rd_d;
  logic [2:0] wr_q, wr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pop_ok;

  // Next-state for storage, pointers and occupancy; empty-queue pops are dropped.
  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    pop_ok = pop && (cnt_q != 3'd0);
    if (clr) begin
      rd_d  = 3'd0;
      wr_d  = 3'd0;
      cnt_d = 3'd0;
    end else begin
      if (push_num != 2'd0) mem_d[wr_q] = push_data[7:0];
      if (push_num == 2'd2) mem_d[ptr_add(wr_q, 2'd1)] = push_data[15:8];
      wr_d = ptr_add(wr_q, push_num);
      if (pop_ok) rd_d = ptr_add(rd_q, 2'd1);
      cnt_d = cnt_q + {1'b0, push_num} - {2'b00, pop_ok};
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      rd_q  <= 3'd0;
      wr_q  <= 3'd0;
      cnt_q <= 3'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Head reads as zero while empty so stale bytes never leak out.
  assign head  = (cnt_q != 3'd0) ? mem_q[rd_q] : 8'h00;
  assign count = cnt_q;

endmodule

// File: rtl/biu_prefetch_queue.sv
// BIU instruction prefetch: forms CS:IP fetch addresses, runs the memory
// request/ack handshake and feeds a 6-byte code queue to decode.
// Optional macro BIU_PREFETCH_STATS_EN adds a saturating fetch_cnt output.
//
// state   | meaning
// IDLE    | no request outstanding; issues when 2+ bytes free and no flush
// FETCH   | request outstanding; ack data is pushed into the queue
// DISCARD | request outstanding but flushed; ack data is dropped
module biu_prefetch_queue
  import biu_defs::*;
#(
  parameter int QUEUE_DEPTH = biu_defs::QUEUE_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cs,
  input  logic        ip_load,
  input  logic [15:0] ip_new,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        q_pop,
  output logic [7:0]  q_byte,
  output logic        q_valid,
  output logic [2:0]  q_count
`ifdef BIU_PREFETCH_STATS_EN
  ,
  output logic [15:0] fetch_cnt
`endif
);

  // Issue only while at least two bytes are free, so a word fetch always fits.
  localparam logic [2:0] ISSUE_MAX = 3'(QUEUE_DEPTH - 2);

  fsm_state_e  state_q, state_d;
  logic [15:0] fetch_ip_q, fetch_ip_d;
  logic [19:0] mem_addr_q, mem_addr_d;
  logic [19:0] phys;
  logic [1:0]  push_num;
  logic [15:0] push_data;
  logic        fifo_clr;
  logic        fifo_pop;
  logic [2:0]  fifo_count;

  assign phys = phys_addr(cs, fetch_ip_q);

  // FSM next-state, fetch pointer advance, queue push and flush control.
  always_comb begin
    state_d    = state_q;
    fetch_ip_d = fetch_ip_q;
    mem_addr_d = mem_addr_q;
    push_num   = 2'd0;
    push_data  = 16'h0000;
    fifo_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ip_load && (fifo_count <= ISSUE_MAX)) begin
          state_d    = FETCH;
          mem_addr_d = phys & 20'hFFFFE;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          state_d = IDLE;
          if (!ip_load) begin
            if (fetch_ip_q[0]) begin
              push_num   = 2'd1;
              push_data  = {8'h00, mem_rdata[15:8]};
              fetch_ip_d = fetch_ip_q + 16'd1;
            end else begin
              push_num   = 2'd2;
              push_data  = mem_rdata;
              fetch_ip_d = fetch_ip_q + 16'd2;
            end
          end
        end else if (ip_load) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ip_load) begin
      fifo_clr   = 1'b1;
      push_num   = 2'd0;
      fetch_ip_d = ip_new;
    end
  end

  assign fifo_pop = q_pop && !ip_load;

  // FSM, fetch pointer and latched request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_ip_q <= 16'h0000;
      mem_addr_q <= 20'h00000;
    end else begin
      state_q    <= state_d;
      fetch_ip_q <= fetch_ip_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  prefetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (fifo_clr),
    .push_num  (push_num),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (q_byte),
    .count     (fifo_count)
  );

  assign mem_req  = (state_q == FETCH) || (state_q == DISCARD);
  assign mem_addr = mem_addr_q;
  assign q_count  = fifo_count;
  assign q_valid  = (fifo_count != 3'd0);

`ifdef BIU_PREFETCH_STATS_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  // Count every acknowledged request, including discarded ones; saturates.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (mem_req && mem_ack && (fetch_cnt_q != 16'hFFFF))
      fetch_cnt_d = fetch_cnt_q + 16'd1;
  end

  // Statistics register; survives flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_cnt_q <= 16'h0000;
    else     fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`else
  // Statistics disabled: no counter state.
`endif

endmodule

// File: tb/tb_biu_prefetch_queue.sv
// Self-checking bench: directed vector table, async-reset sequence, then
// random traffic checked against a queue-based reference model.
module tb_biu_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cs;
  logic        ip_load;
  logic [15:0] ip_new;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        q_pop;
  logic [7:0]  q_byte;
  logic        q_valid;
  logic [2:0]  q_count;
`ifdef BIU_PREFETCH_STATS_EN
  logic [15:0] fetch_cnt;
`endif

  biu_prefetch_queue dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .ip_load   (ip_load),
    .ip_new    (ip_new),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .q_pop     (q_pop),
    .q_byte    (q_byte),
    .q_valid   (q_valid),
    .q_count   (q_count)
`ifdef BIU_PREFETCH_STATS_EN
    ,
    .fetch_cnt (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] cs;
    logic        ld;
    logic [15:0] nip;
    logic        ack;
    logic [15:0] rdata;
    logic        pop;
    logic        e_req;
    logic [19:0] e_addr;
    logic [2:0]  e_cnt;
    logic [7:0]  e_byte;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [15:0] c, input logic ld, input logic [15:0] nip,
                              input logic ack, input logic [15:0] rd, input logic pop,
                              input logic er, input logic [19:0] ea, input logic [2:0] ec,
                              input logic [7:0] eb);
    vec_t v;
    v.cs = c; v.ld = ld; v.nip = nip; v.ack = ack; v.rdata = rd; v.pop = pop;
    v.e_req = er; v.e_addr = ea; v.e_cnt = ec; v.e_byte = eb;
    tbl.push_back(v);
  endfunction

  // Reference model: byte queue plus outstanding-request bookkeeping.
  logic [7:0]  mq[$];
  logic        m_busy;
  logic        m_disc;
  logic [15:0] m_ip;
  logic [19:0] m_addr;
  int          m_cnt;

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_disc = 1'b0;
    m_ip   = 16'h0000;
    m_addr = 20'h00000;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic [15:0] r_cs, input logic r_load, input logic [15:0] r_new,
                            input logic r_ack, input logic [15:0] r_data, input logic r_pop);
    int size0;
    bit acc;
    size0 = mq.size();
    acc   = m_busy && r_ack;
    if (acc && m_cnt < 65535) m_cnt++;
    if (r_load) begin
      mq.delete();
      m_ip = r_new;
      if (m_busy && !r_ack) m_disc = 1'b1;
      else begin m_busy = 1'b0; m_disc = 1'b0; end
    end else begin
      if (r_pop && size0 > 0) void'(mq.pop_front());
      if (acc) begin
        if (!m_disc) begin
          if (m_ip[0] == 1'b0) begin
            mq.push_back(r_data[7:0]);
            mq.push_back(r_data[15:8]);
            m_ip = m_ip + 16'd2;
          end else begin
            mq.push_back(r_data[15:8]);
            m_ip = m_ip + 16'd1;
          end
        end
        m_busy = 1'b0;
        m_disc = 1'b0;
      end else if (!m_busy && size0 <= 4) begin
        m_busy = 1'b1;
        m_addr = ((20'(r_cs) << 4) + 20'(m_ip)) & 20'hFFFFE;
      end
    end
  endtask

  task automatic drive(input logic [15:0] c, input logic ld, input logic [15:0] nip,
                       input logic ack, input logic [15:0] rd, input logic pop);
    cs = c; ip_load = ld; ip_new = nip; mem_ack = ack; mem_rdata = rd; q_pop = pop;
  endtask

  initial begin
    rst = 1'b1;
    drive(16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", mem_req, 1'b0);
    chk("reset_addr", mem_addr, 20'h00000);
    chk("reset_count", q_count, 3'd0);
    chk("reset_valid", q_valid, 1'b0);
    chk("reset_byte", q_byte, 8'h00);
`ifdef BIU_PREFETCH_STATS_EN
    chk("reset_fetch_cnt", fetch_cnt, 16'h0000);
`endif

    //  cs       ld  ip_new   ack rdata    pop  req addr      cnt byte
    add(16'h1000, 0, 16'h0000, 0, 16'h0000, 0,  1, 20'h10000, 0, 8'h00);
    add(16'h1000, 0, 16'h0000, 1, 16'hBBAA, 0,  0, 20'h00000, 2, 8'hAA);
    add(16'h1000, 0, 16'h0000, 0, 16'h0000, 0,  1, 20'h10002, 2, 8'hAA);
    add(16'h1000, 0, 16'h0000, 1, 16'hDDCC, 0,  0, 20'h00000, 4, 8'hAA);
    add(16'h1000, 0, 16'h0000, 0, 16'h0000, 0,  1, 20'h10004, 4, 8'hAA);
    add(16'h1000, 0, 16'h0000, 1, 16'hFFEE, 0,  0, 20'h00000, 6, 8'hAA);
    add(16'h1000, 0, 16'h0000, 0, 16'h0000, 0,  0, 20'h00000, 6, 8'hAA);
    add(16'h1000, 0, 16'h0000, 0, 16'h0000, 0,  0, 20'h00000, 6, 8'hAA);
    add(16'h1000, 0, 16'h0000, 0, 16'h0000, 1,  0, 20'h00000, 5, 8'hBB);
    add(16'h1000, 0, 16'h0000, 0, 16'h0000, 1,  0, 20'h00000, 4, 8'hCC);
    add(16'h1000, 0, 16'h0000, 0, 16'h0000, 0,  1, 20'h10006, 4, 8'hCC);
    add(16'h2000, 1, 16'h0003, 0, 16'h0000, 1,  1, 20'h10006, 0, 8'h00);
    add(16'h2000, 0, 16'h0000, 1, 16'hDEAD, 0,  0, 20'h00000, 0, 8'h00);
    add(16'h2000, 0, 16'h0000, 0, 16'h0000, 0,  1, 20'h20002, 0, 8'h00);
    add(16'h2000, 0, 16'h0000, 1, 16'h5544, 0,  0, 20'h00000, 1, 8'h55);
    add(16'h2000, 0, 16'h0000, 0, 16'h0000, 0,  1, 20'h20004, 1, 8'h55);
    add(16'h2000, 0, 16'h0000, 1, 16'h7766, 1,  0, 20'h00000, 2, 8'h66);
    add(16'h2000, 0, 16'h0000, 0, 16'h0000, 1,  1, 20'h20006, 1, 8'h77);
    add(16'h2000, 0, 16'h0000, 0, 16'h0000, 1,  1, 20'h20006, 0, 8'h00);
    add(16'h2000, 0, 16'h0000, 0, 16'h0000, 1,  1, 20'h20006, 0, 8'h00);
    add(16'h2000, 0, 16'h0000, 1, 16'h1100, 0,  0, 20'h00000, 2, 8'h00);
    add(16'hFFFF, 1, 16'h0010, 0, 16'h0000, 0,  0, 20'h00000, 0, 8'h00);
    add(16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0,  1, 20'h00000, 0, 8'h00);
    add(16'hFFFF, 0, 16'h0000, 1, 16'h0201, 0,  0, 20'h00000, 2, 8'h01);
    add(16'h0000, 1, 16'hFFFE, 0, 16'h0000, 0,  0, 20'h00000, 0, 8'h00);
    add(16'h0000, 0, 16'h0000, 0, 16'h0000, 0,  1, 20'h0FFFE, 0, 8'h00);
    add(16'h0000, 0, 16'h0000, 1, 16'h3322, 0,  0, 20'h00000, 2, 8'h22);
    add(16'h0000, 0, 16'h0000, 0, 16'h0000, 0,  1, 20'h00000, 2, 8'h22);
    add(16'h0000, 1, 16'h0100, 1, 16'h9988, 1,  0, 20'h00000, 0, 8'h00);
    add(16'h0000, 0, 16'h0000, 0, 16'h0000, 0,  1, 20'h00100, 0, 8'h00);

    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cs, tbl[i].ld, tbl[i].nip, tbl[i].ack, tbl[i].rdata, tbl[i].pop);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_req", i), mem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_count", i), q_count, tbl[i].e_cnt);
      chk($sformatf("vec%0d_valid", i), q_valid, tbl[i].e_cnt != 3'd0);
      if (tbl[i].e_cnt != 3'd0) chk($sformatf("vec%0d_byte", i), q_byte, tbl[i].e_byte);
    end
`ifdef BIU_PREFETCH_STATS_EN
    chk("table_fetch_cnt", fetch_cnt, 16'd10);
`endif

    // Async reset while a request is outstanding and bytes are queued.
    drive(16'h0000, 1'b0, 16'h0000, 1'b1, 16'h4321, 1'b0);
    @(posedge clk);
    #1;
    drive(16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_req", mem_req, 1'b1);
    chk("pre_rst_count", q_count, 3'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", mem_req, 1'b0);
    chk("async_rst_count", q_count, 3'd0);
    chk("async_rst_valid", q_valid, 1'b0);
`ifdef BIU_PREFETCH_STATS_EN
    chk("async_rst_fetch_cnt", fetch_cnt, 16'h0000);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Random traffic against the reference model.
    begin
      logic [15:0] r_cs;
      r_cs = 16'h1234;
      for (int n = 0; n < 3000; n++) begin
        logic        r_ld;
        logic [15:0] r_new;
        logic        r_ack;
        logic [15:0] r_data;
        logic        r_pop;
        if ($urandom_range(0, 49) == 0) r_cs = 16'($urandom);
        r_ld   = ($urandom_range(0, 24) == 0);
        r_new  = 16'($urandom);
        r_ack  = ($urandom_range(0, 4) < 2);
        r_data = 16'($urandom);
        r_pop  = ($urandom_range(0, 9) < 4);
        drive(r_cs, r_ld, r_new, r_ack, r_data, r_pop);
        model_step(r_cs, r_ld, r_new, r_ack, r_data, r_pop);
        @(posedge clk);
        #1;
        chk("rnd_req", mem_req, m_busy);
        if (m_busy) chk("rnd_addr", mem_addr, m_addr);
        chk("rnd_count", q_count, mq.size());
        chk("rnd_valid", q_valid, mq.size() != 0);
        if (mq.size() != 0) chk("rnd_byte", q_byte, mq[0]);
`ifdef BIU_PREFETCH_STATS_EN
        chk("rnd_fetch_cnt", fetch_cnt, m_cnt);
`endif
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
